// File: rtl/sha256_message_schedule_pkg.sv
// Shared constants and types for the SHA-256 message schedule expander.
// Word width, schedule length, window depth and the small-sigma rotate/shift amounts.
package sha256_message_schedule_pkg;

    localparam int WORD_W       = 32;
    localparam int SCHED_LEN    = 64;
    localparam int WINDOW_DEPTH = 16;
    localparam int IDX_W        = 6;
    localparam int BLOCK_W      = WORD_W * WINDOW_DEPTH;

    localparam int SIG0_ROT_A = 7;
    localparam int SIG0_ROT_B = 18;
    localparam int SIG0_SHR   = 3;
    localparam int SIG1_ROT_A = 17;
    localparam int SIG1_ROT_B = 19;
    localparam int SIG1_SHR   = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } scheduleState_t;

endpackage

// File: rtl/sha256_small_sigma.sv
// SHA-256 small sigma: rotr(rotA) ^ rotr(rotB) ^ shr(shr), purely combinational wiring plus XOR.
module sha256_small_sigma
    import sha256_message_schedule_pkg::*;
#(
    parameter int rotA = SIG0_ROT_A,
    parameter int rotB = SIG0_ROT_B,
    parameter int shr  = SIG0_SHR
) (
    input  logic [WORD_W-1:0] x,
    output logic [WORD_W-1:0] y
);

    logic [WORD_W-1:0] rotTermA;
    logic [WORD_W-1:0] rotTermB;
    logic [WORD_W-1:0] shrTerm;

    assign rotTermA = (x >> rotA) | (x << (WORD_W - rotA));
    assign rotTermB = (x >> rotB) | (x << (WORD_W - rotB));
    assign shrTerm  = x >> shr;

    assign y = rotTermA ^ rotTermB ^ shrTerm;

endmodule

// File: rtl/sha256_message_schedule.sv
// Expands one 512-bit block into W0..W63 through a 16-word sliding window,
// streaming one word per accepted cycle with valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for a block; blockReady high
// RUN   | streaming window[0] as W[index]; wValid high
module sha256_message_schedule
    import sha256_message_schedule_pkg::*;
(
    input  logic                 clock,
    input  logic                 resetN,
    input  logic [BLOCK_W-1:0]   blockIn,
    input  logic                 blockValid,
    output logic                 blockReady,
    output logic [WORD_W-1:0]    wOut,
    output logic [IDX_W-1:0]     wIndex,
    output logic                 wLast,
    output logic                 wValid,
    input  logic                 wReady
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SCHED_LEN - 1);

    scheduleState_t    state;
    logic [IDX_W-1:0]  index;
    logic [WORD_W-1:0] window [WINDOW_DEPTH];
    logic [WORD_W-1:0] sigma0;
    logic [WORD_W-1:0] sigma1;
    logic [WORD_W-1:0] nextWord;

    sha256_small_sigma #(
        .rotA (SIG0_ROT_A),
        .rotB (SIG0_ROT_B),
        .shr  (SIG0_SHR)
    ) uSigma0 (
        .x (window[1]),
        .y (sigma0)
    );

    sha256_small_sigma #(
        .rotA (SIG1_ROT_A),
        .rotB (SIG1_ROT_B),
        .shr  (SIG1_SHR)
    ) uSigma1 (
        .x (window[14]),
        .y (sigma1)
    );

    // Computed on every shift; words produced past W63 are simply never emitted.
    assign nextWord = sigma1 + window[9] + sigma0 + window[0];

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state <= IDLE;
            index <= '0;
            for (int i = 0; i < WINDOW_DEPTH; i++) begin
                window[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (blockValid) begin
                        for (int i = 0; i < WINDOW_DEPTH; i++) begin
                            window[i] <= blockIn[BLOCK_W-1-WORD_W*i -: WORD_W];
                        end
                        index <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (wReady) begin
                        for (int i = 0; i < WINDOW_DEPTH - 1; i++) begin
                            window[i] <= window[i+1];
                        end
                        window[WINDOW_DEPTH-1] <= nextWord;
                        if (index == LAST_IDX) begin
                            index <= '0;
                            state <= IDLE;
                        end else begin
                            index <= index + IDX_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign blockReady = (state == IDLE);
    assign wValid     = (state == RUN);
    assign wOut       = window[0];
    assign wIndex     = index;
    assign wLast      = (index == LAST_IDX);

endmodule
